// File: rtl/sensor_avg_filter.sv
// Moving-average filter over a 2^LOG2_DEPTH sample window feeding the fixed/float converter.
// Build option: define AVG_ROUND_EN for round-half-up averaging; floor (arithmetic shift) otherwise.
module sensor_avg_filter #(
  parameter int SAMPLE_W   = 16,
  parameter int LOG2_DEPTH = 3,
  parameter int FRAC_BITS  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SAMPLE_W-1:0] sample_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         avg_data,
  output logic [4:0]          avg_fixpointpos,
  output logic                window_full
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SUM_W = SAMPLE_W + LOG2_DEPTH;
  localparam logic [LOG2_DEPTH-1:0] LAST = LOG2_DEPTH'(DEPTH - 1);

  typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;

  state_t                     state_q, state_d;
  logic [LOG2_DEPTH-1:0]      count_q;
  logic [LOG2_DEPTH-1:0]      ptr_q;
  logic signed [SUM_W-1:0]    sum_q;
  logic signed [SAMPLE_W-1:0] mem [DEPTH];

  logic                       accept;
  logic                       produce;
  logic signed [SUM_W-1:0]    samp_ext;
  logic signed [SUM_W-1:0]    old_ext;
  logic signed [SUM_W-1:0]    sum_next;
  logic [31:0]                avg_next;

  // Handshake: a transfer happens on an edge where valid && ready. The
  // producer is stalled only while a result is held waiting for the consumer.
  assign in_ready        = !(out_valid && !out_ready);
  assign accept          = in_valid && in_ready;
  assign avg_fixpointpos = 5'(FRAC_BITS);

  assign samp_ext = SUM_W'($signed(sample_data));
  assign old_ext  = SUM_W'(mem[ptr_q]);
  assign sum_next = sum_q + samp_ext - old_ext;

`ifdef AVG_ROUND_EN
  localparam logic signed [SUM_W:0] HALF = (SUM_W + 1)'(1) << (LOG2_DEPTH - 1);
  logic signed [SUM_W:0] rnd_sum;
  assign rnd_sum  = (SUM_W + 1)'(sum_next) + HALF;
  assign avg_next = 32'(rnd_sum >>> LOG2_DEPTH);
`else
  assign avg_next = 32'(sum_next >>> LOG2_DEPTH);
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= FILL;
    else      state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (flush)
      state_d = FILL;
    else if (state_q == FILL && accept && count_q == LAST)
      state_d = RUN;
  end

  // FSM outputs: the filling accept that completes the window also emits.
  always_comb begin
    window_full = (state_q == RUN);
    produce     = 1'b0;
    if (!flush && accept)
      produce = (state_q == RUN) || (count_q == LAST);
  end

  // Window storage, running sum, fill counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      ptr_q   <= '0;
      sum_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      count_q <= '0;
      ptr_q   <= '0;
      sum_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (accept) begin
      sum_q      <= sum_next;
      mem[ptr_q] <= $signed(sample_data);
      ptr_q      <= ptr_q + 1'b1;
      if (state_q == FILL) count_q <= count_q + 1'b1;
    end
  end

  // Output register: a new result replaces a consumed one on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      avg_data  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      avg_data  <= '0;
    end else if (produce) begin
      out_valid <= 1'b1;
      avg_data  <= avg_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sensor_avg_filter.sv
// Self-checking bench for sensor_avg_filter (window depth 4, 4 fraction bits).
module tb_sensor_avg_filter;

  localparam int SAMPLE_W   = 16;
  localparam int LOG2_DEPTH = 2;
  localparam int DEPTH      = 1 << LOG2_DEPTH;
  localparam int FRAC_BITS  = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [SAMPLE_W-1:0] sample_data;
  logic                out_valid;
  logic                out_ready;
  logic [31:0]         avg_data;
  logic [4:0]          avg_fixpointpos;
  logic                window_full;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  int          win[$];
  int          msum = 0;
  logic [31:0] held;

  sensor_avg_filter #(
    .SAMPLE_W  (SAMPLE_W),
    .LOG2_DEPTH(LOG2_DEPTH),
    .FRAC_BITS (FRAC_BITS)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .sample_data    (sample_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .avg_data       (avg_data),
    .avg_fixpointpos(avg_fixpointpos),
    .window_full    (window_full)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: act=0x%08h exp=0x%08h", tag, act, exp);
    end
  endtask

  // reference model: plain sliding window of integers
  function automatic logic [31:0] model_avg(input int s);
`ifdef AVG_ROUND_EN
    return 32'((s + (1 << (LOG2_DEPTH - 1))) >>> LOG2_DEPTH);
`else
    return 32'(s >>> LOG2_DEPTH);
`endif
  endfunction

  function automatic void model_accept(input logic [SAMPLE_W-1:0] s);
    int v;
    v = int'($signed(s));
    win.push_back(v);
    msum += v;
    if (win.size() > DEPTH) msum -= win.pop_front();
    if (win.size() == DEPTH) exp_q.push_back(model_avg(msum));
  endfunction

  function automatic void model_clear();
    win.delete();
    exp_q.delete();
    msum = 0;
  endfunction

  // scoreboard: a result transfers on the edge after a negedge with valid && ready
  always @(negedge clk) begin
    if (rst && !flush && out_valid && out_ready) begin
      check("out_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("avg_data", avg_data, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic send(input logic [SAMPLE_W-1:0] s);
    int waited = 0;
    in_valid    = 1'b1;
    sample_data = s;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(negedge clk);
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    else           model_accept(s);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    model_clear();
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sample_data = '0;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_avg_data", avg_data, 32'd0);
    check("rst_window_full", 32'(window_full), 32'd0);
    check("rst_fixpos", 32'(avg_fixpointpos), 32'd4);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    idle(1);

    // fill, then sliding updates
    send(16); send(32); send(48);
    check("fill_no_out", 32'(out_valid), 32'd0);
    check("fill_not_full", 32'(window_full), 32'd0);
    send(64);
    check("first_out_valid", 32'(out_valid), 32'd1);
    check("first_avg", avg_data, 32'h0000_0028);
    check("full_fixpos", 32'(avg_fixpointpos), 32'd4);
    check("full_window", 32'(window_full), 32'd1);
    send(80);
    check("slide_avg_80", avg_data, 32'd56);
    send(0);
    check("slide_avg_0", avg_data, 32'd48);
    idle(2);

    // negative values in a fresh window
    do_flush();
    check("flush_not_full", 32'(window_full), 32'd0);
    send(-16'sd3); send(-16'sd2); send(-16'sd2); send(-16'sd2);
`ifdef AVG_ROUND_EN
    check("neg_avg", avg_data, 32'hFFFF_FFFE);
`else
    check("neg_avg", avg_data, 32'hFFFF_FFFD);
`endif

    // backpressure: result held, producer stalled
    out_ready   = 1'b0;
    held        = avg_data;
    in_valid    = 1'b1;
    sample_data = 16'd100;
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_avg_stable", avg_data, held);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    model_accept(16'd100);
    @(negedge clk);
    check("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("bp_new_valid", 32'(out_valid), 32'd1);
    idle(2);

    // flush drops a concurrent sample and the partial window
    do_flush();
    send(1); send(2); send(3);
    in_valid    = 1'b1;
    sample_data = 16'd77;
    do_flush();
    in_valid = 1'b0;
    check("flushdrop_not_full", 32'(window_full), 32'd0);
    check("flushdrop_no_out", 32'(out_valid), 32'd0);
    send(4); send(4); send(4);
    check("refill_no_out", 32'(out_valid), 32'd0);
    send(4);
    check("refill_avg", avg_data, 32'd4);

    // asynchronous reset mid-cycle with a pending result
    out_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_avg_data", avg_data, 32'd0);
    check("arst_window_full", 32'(window_full), 32'd0);
    model_clear();
    @(posedge clk);
    #1 rst = 1'b1;
    out_ready = 1'b1;
    send(8); send(8); send(8);
    check("arst_refill_no_out", 32'(out_valid), 32'd0);
    send(8);
    check("arst_refill_out", 32'(out_valid), 32'd1);
    idle(2);

    // full-scale boundaries
    do_flush();
    repeat (DEPTH) send(16'h7FFF);
    check("max_avg", avg_data, 32'h0000_7FFF);
    repeat (DEPTH) send(16'h8000);
    check("min_avg", avg_data, 32'hFFFF_8000);

    // random samples with random consumer stalls
    for (int i = 0; i < 40; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      send(SAMPLE_W'($urandom_range(0, 65535)));
    end
    out_ready = 1'b1;
    idle(4);
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sensor_avg_filter.md
Name: sensor_avg_filter

Overview:
- Upstream stage of the fixed/float converter.
- Takes raw signed fixed-point temperature samples from the sensor interface and keeps a running moving average over a power-of-two window.
- Emits one 32-bit sign-extended fixed-point result per accepted sample once the window is full, together with the binary-point position.
- Its output pair (avg_data, avg_fixpointpos) drives the converter's number and fix-point-position inputs directly.

Parameters:
- SAMPLE_W, 16: width of the signed input sample.
- LOG2_DEPTH, 3: log2 of the window depth; DEPTH = 2^LOG2_DEPTH; legal range 1..6.
- FRAC_BITS, 4: fraction bits in the sample; driven unchanged onto avg_fixpointpos; legal range 0..SAMPLE_W-1.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: reset, asynchronous, active-low.
- flush, input, 1: synchronous clear of window state.
- in_valid, input, 1: sample_data is valid.
- in_ready, output, 1: block can accept a sample.
- sample_data, input, SAMPLE_W: signed two's-complement sample.
- out_valid, output, 1: avg_data is valid.
- out_ready, input, 1: consumer accepts avg_data.
- avg_data, output, 32: signed average, sign-extended to 32 bits.
- avg_fixpointpos, output, 5: constant FRAC_BITS.
- window_full, output, 1: high in RUN state.

Behaviour:
- Reset (rst low, asynchronous) forces all of the following: out_valid=0, avg_data=0, window_full=0, state=FILL, count=0, write pointer=0, sum=0, all buffer entries=0.
- avg_fixpointpos is always FRAC_BITS, including during reset.
- in_ready is combinational: in_ready = !(out_valid && !out_ready).
- A sample is accepted on a rising edge where in_valid && in_ready.
- Storage: circular buffer of DEPTH entries; pointer wraps from DEPTH-1 to 0.
- Running sum is signed, SAMPLE_W+LOG2_DEPTH bits wide. On accept: sum <= sum + sample - buf[ptr]; buf[ptr] <= sample; ptr <= ptr+1. The evicted entry is zero while filling.
- State FILL:
  - count increments on each accept.
  - The accept that brings count to DEPTH moves the state to RUN and produces the first output.
  - Earlier accepts produce no output.
- State RUN: every accept produces an output. Stays in RUN until flush or reset.
- Output value = (new sum) >>> LOG2_DEPTH (arithmetic shift, floor toward minus infinity), sign-extended to 32 bits.
- Latency: out_valid and avg_data are registered and appear the edge the sample is accepted, i.e. visible in the following cycle.
- out_valid stays high, with avg_data stable, until a cycle with out_ready=1. On that edge out_valid clears, unless a new output is produced on the same edge, in which case out_valid stays 1 and avg_data updates.
- out_valid && out_ready && in_valid in one cycle: both transfers complete. No bubble, no loss.
- While out_valid && !out_ready: in_ready=0 and no sample is accepted. The sample is not lost; the producer holds it.
- flush (synchronous): returns the block to its reset state (except avg_fixpointpos) on the next edge.
  - It overrides any accept in the same cycle; that sample is dropped.
  - A pending output is discarded.
- rst asserted mid-window: all state is lost immediately and the window refills from empty.
- Sum cannot overflow: its width covers DEPTH full-scale samples.

Optional Feature:
- Macro AVG_ROUND_EN.
- When defined: output = (sum + 2^(LOG2_DEPTH-1)) >>> LOG2_DEPTH, i.e. round half up. The addition is done one bit wider to avoid overflow.
- When undefined: plain floor via arithmetic shift.
- Timing, handshake and state behaviour are identical in both builds.

Test Plan:
- LOG2_DEPTH=2, FRAC_BITS=4, out_ready=1; feed 16,32,48,64 -> no output for the first three; after 64, out_valid=1, avg_data=40 (0x00000028), avg_fixpointpos=4, window_full=1.
- Continue with 80 -> evicts 16, sum 224, avg_data=56. Then feed 0 -> evicts 32, sum 192, avg_data=48.
- Negative values, fresh window: -3,-2,-2,-2 (sum -9) -> avg_data=0xFFFFFFFD (-3) without AVG_ROUND_EN; 0xFFFFFFFE (-2) with it.
- Backpressure: with the window full, hold out_ready=0 and present sample 100 -> in_ready=0, avg_data unchanged for 5 cycles. Then raise out_ready -> old result is consumed, 100 is accepted on the same edge, and the new avg_data appears the next cycle.
- flush with in_valid=1 after 3 of 4 fill samples -> the sample is dropped, window_full=0, out_valid=0; the next 4 samples 4,4,4,4 give avg_data=4.
- Pull rst low asynchronously (mid-cycle) while out_valid=1 -> out_valid and avg_data drop to 0 immediately. After release, the first output appears only after DEPTH new accepts.
